// File: rtl/dlbf_coeffs_reader.sv
// Coefficient reader: streams num_words BRAM words (num_reps+1 times) out on AXI4-Stream.
// Optional `DLBF_COEFFS_RD_TUSER_EN adds m_axis_tuser carrying each beat's repetition index.
module dlbf_coeffs_reader #(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        BRAM_PORTB_clk,
    input  logic        BRAM_PORTB_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] base_addr,
    input  logic [15:0] num_words,
    input  logic [7:0]  num_reps,
    output logic [15:0] addrb,
    output logic        enb,
    input  logic [63:0] doutb,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
`ifdef DLBF_COEFFS_RD_TUSER_EN
    output logic [7:0]  m_axis_tuser,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] csr_rddata
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t        r_state;
    state_t        w_nxt;

    logic [15:0]   r_base;
    logic [15:0]   r_words;
    logic [7:0]    r_reps;
    logic [15:0]   r_idx;
    logic [7:0]    r_rep;

    logic          r_vld [RD_LAT];
    logic          r_lst [RD_LAT];

    logic [63:0]   r_fdata [FIFO_DEPTH];
    logic          r_flast [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    logic [15:0]   r_sent;
    logic          r_done;
    logic          r_aborted;

    logic          w_idle;
    logic          w_start_idle;
    logic          w_go;
    logic          w_abort;
    logic [15:0]   w_words;
    logic [7:0]    w_reps;
    logic [15:0]   w_base;
    logic [15:0]   w_idx;
    logic [7:0]    w_rep;
    logic [OW-1:0] w_outst;
    logic [31:0]   w_occ;
    logic          w_room;
    logic          w_enb;
    logic          w_last_word;
    logic          w_last_rep;
    logic          w_final;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_idle       = (r_state == S_IDLE);
    assign w_start_idle = w_idle && start;
    assign w_go         = w_start_idle && (num_words != 16'd0);
    assign w_abort      = abort && (r_state == S_RUN || r_state == S_DRAIN);

    // The first read issues in the start cycle itself, straight from the inputs
    assign w_words = w_idle ? num_words : r_words;
    assign w_reps  = w_idle ? num_reps  : r_reps;
    assign w_base  = w_idle ? base_addr : r_base;
    assign w_idx   = w_idle ? 16'd0     : r_idx;
    assign w_rep   = w_idle ? 8'd0      : r_rep;

    always_comb begin
        w_outst = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_outst = w_outst + OW'(r_vld[i]);
        end
    end

    // A read is only issued when its data is guaranteed a FIFO slot
    assign w_occ  = 32'(w_outst) + 32'(r_cnt);
    assign w_room = (w_occ < 32'(FIFO_DEPTH));

    assign w_last_word = (w_idx == w_words - 16'd1);
    assign w_last_rep  = (w_rep == w_reps);
    assign w_final     = w_enb && w_last_word && w_last_rep;

    assign w_push = r_vld[RD_LAT-1] && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_pop  = (r_cnt != '0) && m_axis_tready;

    always_ff @(posedge BRAM_PORTB_clk) begin
        if (BRAM_PORTB_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_nxt = w_final ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_nxt = S_FLUSH;
                end else if (w_final) begin
                    w_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_nxt = S_FLUSH;
                end else if (w_outst == '0 && r_cnt == '0) begin
                    w_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (w_outst == '0) begin
                    w_nxt = S_IDLE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_enb = 1'b0;
        busy  = 1'b0;
        unique case (r_state)
            S_IDLE:  w_enb = w_go;
            S_RUN: begin
                busy  = 1'b1;
                w_enb = !abort && w_room;
            end
            S_DRAIN: busy = 1'b1;
            S_FLUSH: busy = 1'b1;
            default: ;
        endcase
        if (BRAM_PORTB_rst) begin
            w_enb = 1'b0;
        end
    end

    assign enb   = w_enb;
    assign addrb = w_enb ? (w_base + w_idx) : 16'd0;

    always_ff @(posedge BRAM_PORTB_clk) begin
        if (BRAM_PORTB_rst) begin
            r_base    <= '0;
            r_words   <= '0;
            r_reps    <= '0;
            r_idx     <= '0;
            r_rep     <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_sent    <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_lst[i] <= 1'b0;
            end
        end else begin
            if (w_start_idle) begin
                r_sent    <= '0;
                r_aborted <= 1'b0;
                r_done    <= (num_words == 16'd0);
            end else if (w_pop) begin
                r_sent <= r_sent + 16'd1;
            end
            if (r_state == S_DRAIN && w_nxt == S_IDLE) begin
                r_done <= 1'b1;
            end
            if (w_abort) begin
                r_aborted <= 1'b1;
            end
            if (w_go) begin
                r_base  <= base_addr;
                r_words <= num_words;
                r_reps  <= num_reps;
            end
            if (w_enb) begin
                if (w_last_word) begin
                    r_idx <= 16'd0;
                    r_rep <= w_rep + 8'd1;
                end else begin
                    r_idx <= w_idx + 16'd1;
                    r_rep <= w_rep;
                end
            end
            r_vld[0] <= w_enb;
            r_lst[0] <= w_last_word;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end
            if (w_abort) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wr <= f_inc(r_wr);
                end
                if (w_pop) begin
                    r_rd <= f_inc(r_rd);
                end
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge BRAM_PORTB_clk) begin
        if (w_push) begin
            r_fdata[r_wr] <= doutb;
            r_flast[r_wr] <= r_lst[RD_LAT-1];
        end
    end

    // Head slot is never rewritten while occupied, so stalled beats hold
    assign m_axis_tvalid = (r_cnt != '0);
    assign m_axis_tdata  = m_axis_tvalid ? r_fdata[r_rd] : 64'd0;
    assign m_axis_tlast  = m_axis_tvalid && r_flast[r_rd];

`ifdef DLBF_COEFFS_RD_TUSER_EN
    logic [7:0] r_rtag  [RD_LAT];
    logic [7:0] r_fuser [FIFO_DEPTH];

    always_ff @(posedge BRAM_PORTB_clk) begin
        if (BRAM_PORTB_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_rtag[i] <= '0;
            end
        end else begin
            r_rtag[0] <= w_rep;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rtag[i] <= r_rtag[i-1];
            end
        end
    end

    always_ff @(posedge BRAM_PORTB_clk) begin
        if (w_push) begin
            r_fuser[r_wr] <= r_rtag[RD_LAT-1];
        end
    end

    assign m_axis_tuser = m_axis_tvalid ? r_fuser[r_rd] : 8'd0;
`else
    // without the sideband the repetition tag stops at the issue counter
`endif

    assign done       = r_done;
    assign csr_rddata = {busy, r_done, r_aborted, 5'b0, r_rep, r_sent};

endmodule

// File: tb/tb_dlbf_coeffs_reader.sv
// Directed bench for dlbf_coeffs_reader: vector table plus abort,
// zero-length and mid-run reset sequences against a BRAM model (word i = i).
module tb_dlbf_coeffs_reader;

    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic [7:0]  num_reps;
    logic [15:0] addrb;
    logic        enb;
    logic [63:0] doutb;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        busy;
    logic        done;
    logic [31:0] csr;
`ifdef DLBF_COEFFS_RD_TUSER_EN
    logic [7:0]  tuser;
`endif

    dlbf_coeffs_reader #(
        .RD_LAT(RD_LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .BRAM_PORTB_clk(clk),
        .BRAM_PORTB_rst(rst),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .num_words(num_words),
        .num_reps(num_reps),
        .addrb(addrb),
        .enb(enb),
        .doutb(doutb),
        .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast(tlast),
`ifdef DLBF_COEFFS_RD_TUSER_EN
        .m_axis_tuser(tuser),
`endif
        .busy(busy),
        .done(done),
        .csr_rddata(csr)
    );

    always #5 clk = ~clk;

    // BRAM port B: word at address i holds i; garbage when not enabled
    logic [63:0] bram_p [RD_LAT];
    always @(posedge clk) begin
        bram_p[0] <= enb ? 64'(addrb) : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 1; i < RD_LAT; i++) begin
            bram_p[i] <= bram_p[i-1];
        end
    end
    assign doutb = bram_p[RD_LAT-1];

    typedef struct {
        logic [15:0] base;
        logic [15:0] nw;
        logic [7:0]  nr;
        bit          stall;
        int          exp_beats;
        int          exp_tlast;
        logic [63:0] exp_last;
    } vec_t;

    vec_t tbl [6];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int          issue_k;
    int          beat_k;
    int          inflight;
    int          n_tlast;
    int          first_cyc;
    int          last_cyc;
    logic [63:0] last_data;
    logic [63:0] held_data;
    logic        held_last;
    logic        prev_stall = 1'b0;
    bit          expect_en  = 1'b0;
    bit          vec_mode   = 1'b0;
    logic [15:0] cur_base   = 16'd0;
    logic [15:0] cur_nw     = 16'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic monitor();
        int k;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (start && !busy) begin
                issue_k   = 0;
                beat_k    = 0;
                inflight  = 0;
                n_tlast   = 0;
                first_cyc = -1;
            end
            if (cur_nw == 16'd0) begin
                chk("enb_zero_words", 64'(enb), 64'd0);
            end else if (enb) begin
                k = issue_k % int'(cur_nw);
                chk("addrb", 64'(addrb), 64'(16'(cur_base + 16'(k))));
                issue_k++;
                inflight++;
            end
            if (tvalid && prev_stall) begin
                chk("hold_tdata", tdata, held_data);
                chk("hold_tlast", 64'(tlast), 64'(held_last));
            end
            if (!expect_en) begin
                chk("stray_beat", 64'(tvalid), 64'd0);
            end else if (tvalid && tready && cur_nw != 16'd0) begin
                k = beat_k % int'(cur_nw);
                chk("tdata", tdata, 64'(16'(cur_base + 16'(k))));
                chk("tlast", 64'(tlast), 64'(k == int'(cur_nw) - 1));
`ifdef DLBF_COEFFS_RD_TUSER_EN
                chk("tuser", 64'(tuser), 64'(8'(beat_k / int'(cur_nw))));
`endif
                if (tlast) n_tlast++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc  = cyc;
                last_data = tdata;
                beat_k++;
                inflight--;
            end
            if (vec_mode) begin
                chk("fifo_bound", 64'(inflight <= DEPTH), 64'd1);
            end
            prev_stall = tvalid && !tready;
            held_data  = tdata;
            held_last  = tlast;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_enb"},    64'(enb),    64'd0);
        chk({tag, "_addrb"},  64'(addrb),  64'd0);
        chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
        chk({tag, "_tlast"},  64'(tlast),  64'd0);
        chk({tag, "_tdata"},  tdata,       64'd0);
        chk({tag, "_busy"},   64'(busy),   64'd0);
        chk({tag, "_done"},   64'(done),   64'd0);
        chk({tag, "_csr"},    64'(csr),    64'd0);
    endtask

    task automatic launch(input logic [15:0] b, input logic [15:0] nw, input logic [7:0] nr);
        cur_base  = b;
        cur_nw    = nw;
        base_addr = b;
        num_words = nw;
        num_reps  = nr;
        start     = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int s;
        expect_en = 1'b1;
        vec_mode  = 1'b1;
        tready    = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
        launch(v.base, v.nw, v.nr);
        s = cyc;
        tick();
        start = 1'b0;
        chk("go_busy", 64'(busy), 64'd1);
        chk("go_done_cleared", 64'(done), 64'd0);
        for (int i = 0; i < 4000 && busy; i++) begin
            tready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("beats", 64'(beat_k), 64'(v.exp_beats));
        chk("tlast_count", 64'(n_tlast), 64'(v.exp_tlast));
        chk("last_data", last_data, v.exp_last);
        chk("done_sticky", 64'(done), 64'd1);
        chk("csr_flags", 64'(csr[31:29]), 64'd2);
        chk("csr_words_sent", 64'(csr[15:0]), 64'(16'(v.exp_beats)));
        if (!v.stall) begin
            chk("first_latency", 64'(first_cyc - s), 64'(RD_LAT + 1));
            chk("stream_rate", 64'(last_cyc - first_cyc), 64'(v.exp_beats - 1));
        end
        vec_mode  = 1'b0;
        expect_en = 1'b0;
        tready    = 1'b1;
        tick();
    endtask

    initial begin
        tbl[0] = '{16'h0010, 16'd4,  8'd1,  1'b0, 8,   2,  64'h13};
        tbl[1] = '{16'hFFFE, 16'd4,  8'd0,  1'b0, 4,   1,  64'h1};
        tbl[2] = '{16'h0100, 16'd1,  8'd2,  1'b1, 3,   3,  64'h100};
        tbl[3] = '{16'h0020, 16'd16, 8'd15, 1'b1, 256, 16, 64'h2F};
        tbl[4] = '{16'h0005, 16'd3,  8'd3,  1'b0, 12,  4,  64'h7};
        tbl[5] = '{16'h0007, 16'd1,  8'd0,  1'b0, 1,   1,  64'h7};

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        tready    = 1'b1;
        base_addr = 16'd0;
        num_words = 16'd0;
        num_reps  = 8'd0;
        repeat (3) tick();
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_vec(tbl[v]);
        end

        // abort in the 6th RUN cycle with the sink stalled
        expect_en = 1'b1;
        vec_mode  = 1'b1;
        tready    = 1'b0;
        launch(16'h0040, 16'd16, 8'd0);
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_abort_tvalid", 64'(tvalid), 64'd1);
        chk("pre_abort_tdata", tdata, 64'h40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_tvalid", 64'(tvalid), 64'd0);
        chk("abort_enb", 64'(enb), 64'd0);
        chk("abort_flush_busy", 64'(busy), 64'd1);
        repeat (RD_LAT - 1) tick();
        chk("abort_idle_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_csr_aborted", 64'(csr[29]), 64'd1);
        chk("abort_csr_busy_done", 64'(csr[31:30]), 64'd0);
        vec_mode  = 1'b0;
        expect_en = 1'b0;
        tready    = 1'b1;
        repeat (4) tick();

        // zero-length start
        launch(16'h0300, 16'd0, 8'd0);
        tick();
        start = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("zero_busy_hold", 64'(busy), 64'd0);
        end

        // reset in the middle of a run
        expect_en = 1'b1;
        vec_mode  = 1'b1;
        launch(16'h0200, 16'd8, 8'd3);
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("midrun_streaming", 64'(tvalid), 64'd1);
        rst = 1'b1;
        tick();
        chk_reset_outs("midrun_reset");
        rst       = 1'b0;
        vec_mode  = 1'b0;
        expect_en = 1'b0;
        repeat (20) tick();
        chk("post_reset_busy", 64'(busy), 64'd0);

        run_vec(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
